// File: rtl/clks_alot_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clks_alot_lock_sequencer (with clks_alot_lock_sequencer_pkg)
// Purpose  : Frequency lock-in sequencer. Classifies measured clock
//            half-periods against a configurable band, counts consecutive
//            in-band samples to declare lock, detects sample starvation
//            (pause or under-frequency) and emits one-cycle violation pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk_i              in   1       block clock, rising edge
//   sys_srst_i             in   1       synchronous active-high reset
//   enable_i               in   1       sequencer run enable
//   rate_valid_i           in   1       strobe: new half-period sample
//   rate_is_high_i         in   1       1 = high half-period sample
//   measured_rate_i        in   RATE_W  half-period in sys_clk_i cycles
//   conf_i                 in   struct  mode bits + high/low band limits
//   pausable_i             in   1       starvation may enter PAUSED
//   pause_timeout_i        in   RATE_W  idle cycles before pause (0 = off)
//   status_o               out  struct  pause_active, pause_duration, locked
//   over_freq_violation_o  out  1       one-cycle pulse, rate below band
//   under_freq_violation_o out  1       one-cycle pulse, rate above band
//   state_o                out  2       IDLE=0 ACQUIRE=1 LOCKED=2 PAUSED=3
//   lock_loss_count_o      out  16      only with CLKS_ALOT_LOCK_STATS_EN
// Build option
//   CLKS_ALOT_LOCK_STATS_EN : adds saturating LOCKED->ACQUIRE loss counter
// ============================================================================

package clks_alot_lock_sequencer_pkg;
    localparam int RATE_COUNTER_WIDTH = 32;

    typedef struct packed {
        logic lockin_enabled;
        logic even_50_50_en;
    } duty_cycle_mode_s;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0] lockin_rate;
        logic [RATE_COUNTER_WIDTH-1:0] minimum_band_minus_one;
        logic [RATE_COUNTER_WIDTH-1:0] maximum_band_minus_one;
        logic [RATE_COUNTER_WIDTH-1:0] required_lockin_duration;
    } rate_limits_s;

    typedef struct packed {
        duty_cycle_mode_s mode;
        rate_limits_s     high_limits;
        rate_limits_s     low_limits;
    } duty_cycle_conf_s;

    typedef struct packed {
        logic                          pause_active;
        logic [RATE_COUNTER_WIDTH-1:0] pause_duration;
        logic                          locked;
    } status_s;
endpackage

module clks_alot_lock_sequencer
    import clks_alot_lock_sequencer_pkg::*;
#(
    parameter int RATE_W = RATE_COUNTER_WIDTH
) (
    input  logic              sys_clk_i,
    input  logic              sys_srst_i,
    input  logic              enable_i,
    input  logic              rate_valid_i,
    input  logic              rate_is_high_i,
    input  logic [RATE_W-1:0] measured_rate_i,
    input  duty_cycle_conf_s  conf_i,
    input  logic              pausable_i,
    input  logic [RATE_W-1:0] pause_timeout_i,
    output status_s           status_o,
    output logic              over_freq_violation_o,
    output logic              under_freq_violation_o,
    output logic [1:0]        state_o
`ifdef CLKS_ALOT_LOCK_STATS_EN
    ,
    output logic [15:0]       lock_loss_count_o
`endif
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE = 2'd1;
    localparam logic [1:0] c_ST_LOCKED  = 2'd2;
    localparam logic [1:0] c_ST_PAUSED  = 2'd3;

    localparam logic [RATE_W-1:0] c_ONE   = RATE_W'(1);
    localparam logic [RATE_W:0]   c_ONE_X = (RATE_W+1)'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [1:0]        prepause_q, prepause_d;
    logic              locked_q, locked_d;
    logic              pause_active_q, pause_active_d;
    logic [RATE_W-1:0] pause_dur_q, pause_dur_d;
    logic [RATE_W-1:0] count_q, count_d;
    logic [RATE_W-1:0] idle_q, idle_d;
    logic              over_q, over_d;
    logic              under_q, under_d;

    // ------------------------------------------------------------------
    // Band computation for the current sample
    // ------------------------------------------------------------------
    rate_limits_s      w_lim;
    logic [RATE_W-1:0] w_lockin;
    logic [RATE_W-1:0] w_req;
    logic [RATE_W-1:0] w_req_eff;
    logic [RATE_W:0]   w_lockin_x;
    logic [RATE_W:0]   w_lo_span;
    logic [RATE_W:0]   w_hi_sum;
    logic [RATE_W-1:0] w_band_lo;
    logic [RATE_W-1:0] w_band_hi;
    logic              w_over;
    logic              w_under;
    logic              w_in_band;
    logic [RATE_W-1:0] w_cnt_inc;
    logic [RATE_W-1:0] w_idle_inc;
    logic [RATE_W-1:0] w_dur_inc;
    logic              w_timeout;

    // In 50/50 mode both half-periods share the high-limit set.
    assign w_lim = (rate_is_high_i || conf_i.mode.even_50_50_en) ?
                   conf_i.high_limits : conf_i.low_limits;

    assign w_lockin   = RATE_W'(w_lim.lockin_rate);
    assign w_req      = RATE_W'(w_lim.required_lockin_duration);
    assign w_req_eff  = (w_req == '0) ? c_ONE : w_req;
    assign w_lockin_x = {1'b0, w_lockin};

    // Extended-width arithmetic so the band edges clamp instead of wrapping.
    assign w_lo_span = {1'b0, RATE_W'(w_lim.minimum_band_minus_one)} + c_ONE_X;
    assign w_hi_sum  = w_lockin_x + {1'b0, RATE_W'(w_lim.maximum_band_minus_one)} + c_ONE_X;

    // When no underflow occurs, w_lo_span fits in RATE_W bits.
    assign w_band_lo = (w_lo_span > w_lockin_x) ? '0 : (w_lockin - w_lo_span[RATE_W-1:0]);
    assign w_band_hi = w_hi_sum[RATE_W] ? '1 : w_hi_sum[RATE_W-1:0];

    assign w_under   = (measured_rate_i > w_band_hi);
    assign w_over    = (measured_rate_i < w_band_lo);
    assign w_in_band = !w_under && !w_over;

    assign w_cnt_inc  = (count_q == '1)     ? count_q     : count_q + c_ONE;
    assign w_idle_inc = (idle_q == '1)      ? idle_q      : idle_q + c_ONE;
    assign w_dur_inc  = (pause_dur_q == '1) ? pause_dur_q : pause_dur_q + c_ONE;
    assign w_timeout  = (pause_timeout_i != '0) && (w_idle_inc >= pause_timeout_i);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        prepause_d     = prepause_q;
        locked_d       = locked_q;
        pause_active_d = pause_active_q;
        pause_dur_d    = pause_dur_q;
        count_d        = count_q;
        idle_d         = idle_q;
        over_d         = 1'b0;
        under_d        = 1'b0;

        if (!enable_i) begin
            // Disable dominates samples and timeouts alike.
            state_d        = c_ST_IDLE;
            prepause_d     = c_ST_IDLE;
            locked_d       = 1'b0;
            pause_active_d = 1'b0;
            pause_dur_d    = '0;
            count_d        = '0;
            idle_d         = '0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    locked_d = 1'b0;
                    count_d  = '0;
                    idle_d   = '0;
                    state_d  = c_ST_ACQUIRE;
                end

                c_ST_ACQUIRE, c_ST_LOCKED: begin
                    if (rate_valid_i) begin
                        // A sample always beats a coincident idle timeout.
                        idle_d  = '0;
                        over_d  = w_over;
                        under_d = w_under;
                        if (state_q == c_ST_ACQUIRE) begin
                            if (!conf_i.mode.lockin_enabled) begin
                                state_d  = c_ST_LOCKED;
                                locked_d = 1'b1;
                                count_d  = '0;
                            end else if (w_in_band) begin
                                count_d = w_cnt_inc;
                                if (w_cnt_inc >= w_req_eff) begin
                                    state_d  = c_ST_LOCKED;
                                    locked_d = 1'b1;
                                end
                            end else begin
                                count_d = '0;
                            end
                        end else if (!w_in_band && conf_i.mode.lockin_enabled) begin
                            state_d  = c_ST_ACQUIRE;
                            locked_d = 1'b0;
                            count_d  = '0;
                        end
                    end else if (w_timeout) begin
                        idle_d = '0;
                        if (pausable_i) begin
                            state_d        = c_ST_PAUSED;
                            prepause_d     = state_q;
                            pause_active_d = 1'b1;
                            pause_dur_d    = '0;
                        end else begin
                            // Starvation without pause permission reads as
                            // the input clock having slowed to nothing.
                            under_d  = 1'b1;
                            state_d  = c_ST_ACQUIRE;
                            locked_d = 1'b0;
                            count_d  = '0;
                        end
                    end else begin
                        idle_d = w_idle_inc;
                    end
                end

                c_ST_PAUSED: begin
                    if (rate_valid_i) begin
                        // First sample after a pause is stale: discard it.
                        state_d        = prepause_q;
                        pause_active_d = 1'b0;
                        idle_d         = '0;
                    end else begin
                        pause_dur_d = w_dur_inc;
                    end
                end

                default: state_d = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_srst_i) begin
            state_q        <= c_ST_IDLE;
            prepause_q     <= c_ST_IDLE;
            locked_q       <= 1'b0;
            pause_active_q <= 1'b0;
            pause_dur_q    <= '0;
            count_q        <= '0;
            idle_q         <= '0;
            over_q         <= 1'b0;
            under_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            prepause_q     <= prepause_d;
            locked_q       <= locked_d;
            pause_active_q <= pause_active_d;
            pause_dur_q    <= pause_dur_d;
            count_q        <= count_d;
            idle_q         <= idle_d;
            over_q         <= over_d;
            under_q        <= under_d;
        end
    end

`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [15:0] lock_loss_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_srst_i) begin
            lock_loss_q <= '0;
        end else if ((state_q == c_ST_LOCKED) && (state_d == c_ST_ACQUIRE) &&
                     (lock_loss_q != 16'hFFFF)) begin
            lock_loss_q <= lock_loss_q + 16'd1;
        end
    end

    assign lock_loss_count_o = lock_loss_q;
`endif

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign status_o = '{pause_active:   pause_active_q,
                        pause_duration: RATE_COUNTER_WIDTH'(pause_dur_q),
                        locked:         locked_q};
    assign over_freq_violation_o  = over_q;
    assign under_freq_violation_o = under_q;
    assign state_o                = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clks_alot_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clks_alot_lock_sequencer
// Purpose  : Directed self-checking bench for clks_alot_lock_sequencer.
//            Inputs change 1 ns after a rising edge; outputs are observed
//            at the same point, one edge after the stimulus was captured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clks_alot_lock_sequencer;
    import clks_alot_lock_sequencer_pkg::*;

    localparam int RATE_W = 32;

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic              enable = 1'b0;
    logic              valid = 1'b0;
    logic              is_high = 1'b1;
    logic [RATE_W-1:0] rate = '0;
    duty_cycle_conf_s  conf;
    logic              pausable = 1'b0;
    logic [RATE_W-1:0] timeout = '0;
    status_s           status;
    logic              over_v;
    logic              under_v;
    logic [1:0]        state;
`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [15:0]       loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clks_alot_lock_sequencer #(.RATE_W(RATE_W)) dut (
        .sys_clk_i              (clk),
        .sys_srst_i             (srst),
        .enable_i               (enable),
        .rate_valid_i           (valid),
        .rate_is_high_i         (is_high),
        .measured_rate_i        (rate),
        .conf_i                 (conf),
        .pausable_i             (pausable),
        .pause_timeout_i        (timeout),
        .status_o               (status),
        .over_freq_violation_o  (over_v),
        .under_freq_violation_o (under_v),
        .state_o                (state)
`ifdef CLKS_ALOT_LOCK_STATS_EN
        ,
        .lock_loss_count_o      (loss_cnt)
`endif
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [RATE_W-1:0] r, input logic hi);
        valid   = 1'b1;
        rate    = r;
        is_high = hi;
        tick();
        valid   = 1'b0;
    endtask

    task automatic set_high(input logic [31:0] lk, input logic [31:0] mn,
                            input logic [31:0] mx, input logic [31:0] rq);
        conf.high_limits.lockin_rate              = lk;
        conf.high_limits.minimum_band_minus_one   = mn;
        conf.high_limits.maximum_band_minus_one   = mx;
        conf.high_limits.required_lockin_duration = rq;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        srst   = 1'b1;
        enable = 1'b1;
        valid  = 1'b1;
        rate   = 32'd100;
        tick();
        valid  = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (status.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", status.locked); end
        n_checks++; if (status.pause_active !== 1'b0 || status.pause_duration !== 32'd0) begin n_fail++; $display("FAIL reset_pause: got act=%0b dur=%0d expected 0/0", status.pause_active, status.pause_duration); end
        n_checks++; if (over_v !== 1'b0 || under_v !== 1'b0) begin n_fail++; $display("FAIL reset_viol: got over=%0b under=%0b expected 0/0", over_v, under_v); end
        srst = 1'b0;
    endtask

    task automatic test_lock_acquire();
        conf.mode.lockin_enabled = 1'b1;
        conf.mode.even_50_50_en  = 1'b1;
        set_high(100, 4, 4, 3);
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL acquire_entry: got %0d expected 1", state); end
        send(100, 1'b1);
        send(103, 1'b0);
        n_checks++; if (status.locked !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL acquire_two: got locked=%0b state=%0d expected 0/1", status.locked, state); end
        send(97, 1'b1);
        n_checks++; if (status.locked !== 1'b1 || state !== 2'd2) begin n_fail++; $display("FAIL lock_third: got locked=%0b state=%0d expected 1/2", status.locked, state); end
        n_checks++; if (over_v !== 1'b0 || under_v !== 1'b0) begin n_fail++; $display("FAIL lock_noviol: got over=%0b under=%0b expected 0/0", over_v, under_v); end
    endtask

    task automatic test_violation();
        send(106, 1'b1);
        n_checks++; if (under_v !== 1'b1 || over_v !== 1'b0) begin n_fail++; $display("FAIL under_pulse: got under=%0b over=%0b expected 1/0", under_v, over_v); end
        n_checks++; if (status.locked !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL loss_state: got locked=%0b state=%0d expected 0/1", status.locked, state); end
        tick();
        n_checks++; if (under_v !== 1'b0) begin n_fail++; $display("FAIL under_one_cycle: got %0b expected 0", under_v); end
        send(94, 1'b1);
        n_checks++; if (over_v !== 1'b1 || under_v !== 1'b0) begin n_fail++; $display("FAIL over_pulse: got over=%0b under=%0b expected 1/0", over_v, under_v); end
        send(95, 1'b1);
        n_checks++; if (over_v !== 1'b0 || under_v !== 1'b0) begin n_fail++; $display("FAIL low_edge_inband: got over=%0b under=%0b expected 0/0", over_v, under_v); end
    endtask

    task automatic test_lockin_disabled();
        conf.mode.lockin_enabled = 1'b0;
        send(500, 1'b1);
        n_checks++; if (state !== 2'd2 || status.locked !== 1'b1) begin n_fail++; $display("FAIL nolockin_first: got state=%0d locked=%0b expected 2/1", state, status.locked); end
        send(500, 1'b1);
        n_checks++; if (under_v !== 1'b1 || state !== 2'd2 || status.locked !== 1'b1) begin n_fail++; $display("FAIL nolockin_persist: got under=%0b state=%0d locked=%0b expected 1/2/1", under_v, state, status.locked); end
        // Disable while a violating sample arrives: disable wins.
        enable = 1'b0;
        valid  = 1'b1;
        rate   = 32'd500;
        tick();
        valid  = 1'b0;
        n_checks++; if (state !== 2'd0 || status.locked !== 1'b0 || under_v !== 1'b0) begin n_fail++; $display("FAIL disable_locked: got state=%0d locked=%0b under=%0b expected 0/0/0", state, status.locked, under_v); end
        conf.mode.lockin_enabled = 1'b1;
    endtask

    task automatic test_pause();
        pausable = 1'b1;
        timeout  = 32'd50;
        enable   = 1'b1;
        tick();
        send(100, 1'b1);
        send(100, 1'b1);
        send(100, 1'b1);
        idle_cycles(49);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_early: got state=%0d expected 2", state); end
        tick();
        n_checks++; if (state !== 2'd3 || status.pause_active !== 1'b1 || status.locked !== 1'b1) begin n_fail++; $display("FAIL pause_entry: got state=%0d act=%0b locked=%0b expected 3/1/1", state, status.pause_active, status.locked); end
        idle_cycles(20);
        send(5000, 1'b1);
        n_checks++; if (state !== 2'd2 || over_v !== 1'b0 || under_v !== 1'b0) begin n_fail++; $display("FAIL pause_exit: got state=%0d over=%0b under=%0b expected 2/0/0", state, over_v, under_v); end
        n_checks++; if (status.pause_active !== 1'b0 || status.pause_duration !== 32'd20) begin n_fail++; $display("FAIL pause_duration: got act=%0b dur=%0d expected 0/20", status.pause_active, status.pause_duration); end
        tick();
        n_checks++; if (status.pause_duration !== 32'd20 || status.locked !== 1'b1) begin n_fail++; $display("FAIL pause_hold: got dur=%0d locked=%0b expected 20/1", status.pause_duration, status.locked); end
    endtask

    task automatic test_timeout_unpausable();
        pausable = 1'b0;
        send(100, 1'b1);
        idle_cycles(49);
        n_checks++; if (under_v !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL starve_early: got under=%0b state=%0d expected 0/2", under_v, state); end
        tick();
        n_checks++; if (under_v !== 1'b1 || state !== 2'd1 || status.locked !== 1'b0) begin n_fail++; $display("FAIL starve_timeout: got under=%0b state=%0d locked=%0b expected 1/1/0", under_v, state, status.locked); end
    endtask

    task automatic test_coincide_and_reset();
        pausable = 1'b1;
        timeout  = 32'd5;
        idle_cycles(4);
        send(100, 1'b1);
        n_checks++; if (state !== 2'd1 || status.pause_active !== 1'b0) begin n_fail++; $display("FAIL coincide_sample_wins: got state=%0d act=%0b expected 1/0", state, status.pause_active); end
        idle_cycles(4);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL coincide_idle_cleared: got state=%0d expected 1", state); end
        tick();
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL coincide_pause: got state=%0d expected 3", state); end
        idle_cycles(3);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        n_checks++; if (state !== 2'd0 || status.pause_active !== 1'b0 || status.pause_duration !== 32'd0 || status.locked !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pause: got state=%0d act=%0b dur=%0d locked=%0b expected 0/0/0/0", state, status.pause_active, status.pause_duration, status.locked); end
        timeout  = 32'd0;
        pausable = 1'b0;
    endtask

    task automatic test_band_edges();
        set_high(2, 5, 0, 1);
        tick();
        send(0, 1'b1);
        n_checks++; if (over_v !== 1'b0 || status.locked !== 1'b1) begin n_fail++; $display("FAIL low_saturate: got over=%0b locked=%0b expected 0/1", over_v, status.locked); end
        enable = 1'b0;
        tick();
        set_high(32'hFFFF_FFFF, 4, 3, 1);
        enable = 1'b1;
        tick();
        send(32'hFFFF_FFFF, 1'b1);
        n_checks++; if (under_v !== 1'b0 || status.locked !== 1'b1) begin n_fail++; $display("FAIL high_saturate: got under=%0b locked=%0b expected 0/1", under_v, status.locked); end
    endtask

    task automatic test_low_limits();
        enable = 1'b0;
        tick();
        conf.mode.even_50_50_en = 1'b0;
        set_high(100, 4, 4, 1);
        conf.low_limits.lockin_rate              = 32'd50;
        conf.low_limits.minimum_band_minus_one   = 32'd4;
        conf.low_limits.maximum_band_minus_one   = 32'd4;
        conf.low_limits.required_lockin_duration = 32'd1;
        enable = 1'b1;
        tick();
        send(50, 1'b1);
        n_checks++; if (over_v !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL high_set_used: got over=%0b state=%0d expected 1/1", over_v, state); end
        send(50, 1'b0);
        n_checks++; if (over_v !== 1'b0 || under_v !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL low_set_used: got over=%0b under=%0b state=%0d expected 0/0/2", over_v, under_v, state); end
        conf.mode.even_50_50_en = 1'b1;
    endtask

`ifdef CLKS_ALOT_LOCK_STATS_EN
    task automatic test_stats();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        n_checks++; if (loss_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d expected 0", loss_cnt); end
        set_high(100, 4, 4, 3);
        tick();
        for (int k = 0; k < 2; k++) begin
            send(100, 1'b1);
            send(100, 1'b1);
            send(100, 1'b1);
            send(106, 1'b1);
        end
        n_checks++; if (loss_cnt !== 16'd2) begin n_fail++; $display("FAIL stats_count: got %0d expected 2", loss_cnt); end
    endtask
`endif

    initial begin
        conf = '0;
        test_reset();
        test_lock_acquire();
        test_violation();
        test_lockin_disabled();
        test_pause();
        test_timeout_unpausable();
        test_coincide_and_reset();
        test_band_edges();
        test_low_limits();
`ifdef CLKS_ALOT_LOCK_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // One-cycle violation pulses must never coincide.
    always @(negedge clk) begin
        if (over_v === 1'b1 && under_v === 1'b1) begin
            n_fail++;
            $display("FAIL exclusive_viol: got over=1 under=1 expected not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/clks_alot_lock_sequencer.md
CLKS_ALOT_LOCK_SEQUENCER -- requirements
Module: clks_alot_lock_sequencer

Interface
REQ-001 SHALL have parameter RATE_W, default 32, width of rate, band, duration and pause counters (matches RATE_COUNTER_WIDTH).
REQ-002 SHALL have port sys_clk_i  input  1  single block clock; all logic on rising edge.
REQ-003 SHALL have port sys_srst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable_i  input  1  sequencer run enable.
REQ-005 SHALL have port rate_valid_i  input  1  one-cycle strobe: new measured half-period available.
REQ-006 SHALL have port rate_is_high_i  input  1  1 = sample is a high half-period, 0 = low half-period.
REQ-007 SHALL have port measured_rate_i  input  RATE_W  measured half-period, in sys_clk_i cycles.
REQ-008 SHALL have port conf_i  input  duty_cycle_conf_s  mode bits plus high/low half-rate limits.
REQ-009 SHALL have ports pausable_i  input  1  (pause allowed) and pause_timeout_i  input  RATE_W  (idle cycles before pause; 0 disables detection).
REQ-010 SHALL have port status_o  output  status_s  pause_active, pause_duration, locked.
REQ-011 SHALL have ports over_freq_violation_o and under_freq_violation_o  output  1 each  one-cycle violation pulses.
REQ-012 SHALL have port state_o  output  2  encoded FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, PAUSED=3.

Function
REQ-013 SHALL select high_limits when rate_is_high_i=1 or mode.even_50_50_en=1, else low_limits.
REQ-014 SHALL compute band low = lockin_rate-(minimum_band_minus_one+1), saturating at 0, and band high = lockin_rate+maximum_band_minus_one+1, saturating at all-ones, using RATE_W+1-bit intermediates.
REQ-015 SHALL classify a sample as in-band when low <= rate <= high, under-frequency when rate > high, over-frequency when rate < low.
REQ-016 SHALL register all outputs: a sample strobed in cycle N affects outputs in cycle N+1.
REQ-017 IDLE: locked=0, counters cleared; go to ACQUIRE when enable_i=1.
REQ-018 ACQUIRE: count consecutive in-band samples (saturating); go to LOCKED when count reaches max(required_lockin_duration,1); an out-of-band sample clears the count and pulses the matching violation output.
REQ-019 LOCKED: locked=1; an out-of-band sample pulses the violation output and, when mode.lockin_enabled=1, returns the FSM to ACQUIRE with count 0 and locked=0.
REQ-020 With mode.lockin_enabled=0, ACQUIRE SHALL go to LOCKED on the first sample of any value, and LOCKED SHALL persist through violations, which are still pulsed.
REQ-021 In ACQUIRE/LOCKED, an idle counter SHALL count cycles without rate_valid_i; on reaching a nonzero pause_timeout_i: if pausable_i=1 go to PAUSED, else pulse under_freq_violation_o and go to ACQUIRE with count 0.
REQ-022 PAUSED: pause_active=1; pause_duration increments per cycle, saturating at all-ones; locked holds its pre-pause value; the next rate_valid_i SHALL be discarded without band check and the FSM returns to its pre-pause state.
REQ-023 pause_duration SHALL hold its last value after the pause ends and clear on entry to the next PAUSED.
REQ-024 When rate_valid_i and the idle timeout coincide, the sample SHALL win and the idle counter SHALL clear.
REQ-025 enable_i=0 SHALL force IDLE next cycle from any state, with priority over samples and timeouts; no violation pulses SHALL occur in IDLE.
REQ-026 over_freq_violation_o and under_freq_violation_o SHALL never assert in the same cycle.

Reset
REQ-027 sys_srst_i=1 SHALL, at the next edge, set state IDLE, locked=0, pause_active=0, pause_duration=0, violations=0, and clear all counters; reset overrides every other input.

Configuration
REQ-028 With macro CLKS_ALOT_LOCK_STATS_EN defined, the block SHALL add output lock_loss_count_o (16 bits), a saturating count of LOCKED->ACQUIRE transitions cleared by reset; without the macro, this port and its logic SHALL be absent.

Verification
REQ-029 lockin_rate=100, min/max_minus_one=4, required=3, even_50_50=1; samples 100,103,97 -> locked=1 the cycle after the third sample; state_o=2.
REQ-030 Locked as in REQ-029, lockin_enabled=1; sample 106 -> under_freq pulse, locked=0, state_o=1; sample 94 -> over_freq pulse.
REQ-031 Locked; pausable=1, timeout=50; no strobe for 50 cycles -> state_o=3, pause_active=1, locked=1; strobe with rate 5000 after 20 more cycles -> no violation, state_o=2, pause_duration holds 20 (+/-1 per the registered edge).
REQ-032 pausable=0, timeout=50, locked; 50 idle cycles -> under_freq pulse, state_o=1.
REQ-033 lockin_rate=2, min_minus_one=5 -> low bound saturates at 0; sample 0 is in-band; lockin_rate=all-ones, max_minus_one=3 -> no wrap, sample all-ones is in-band.
REQ-034 Reset asserted mid-pause, and enable_i dropped in LOCKED -> all outputs at reset values, state_o=0 next cycle; with CLKS_ALOT_LOCK_STATS_EN, lock_loss_count_o counts 2 after two REQ-030 losses.
